// File: rtl/alu_pkg.sv
// Shared types for the ALU result stage: condition codes, flag bit positions
// and the skid-buffer state encoding.
package alu_pkg;

    // 4-bit condition code carried with each op
    typedef enum logic [3:0] {
        EQ = 4'h0,
        NE = 4'h1,
        CS = 4'h2,
        CC = 4'h3,
        MI = 4'h4,
        PL = 4'h5,
        VS = 4'h6,
        VC = 4'h7,
        HI = 4'h8,
        LS = 4'h9,
        GE = 4'hA,
        LT = 4'hB,
        GT = 4'hC,
        LE = 4'hD,
        AL = 4'hE,
        NV = 4'hF
    } cond_e;

    // Bit positions of the flags inside the packed {N,Z,C,V} vector
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Occupancy of the 2-entry output skid buffer
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } skid_state_e;

endpackage

// File: rtl/cond_eval.sv
// Combinational condition-code evaluator: decides whether an op with the
// given condition executes against the supplied {N,Z,C,V} flags.
module cond_eval
    import alu_pkg::*;
(
    input  cond_e      cond,
    input  logic [3:0] nzcv,
    output logic       pass
);

    logic n, z, c, v;

    assign n = nzcv[FLAG_N];
    assign z = nzcv[FLAG_Z];
    assign c = nzcv[FLAG_C];
    assign v = nzcv[FLAG_V];

    // Decode the condition; NV is reserved and never executes
    always_comb begin
        pass = 1'b0;
        case (cond)
            EQ:      pass = z;
            NE:      pass = !z;
            CS:      pass = c;
            CC:      pass = !c;
            MI:      pass = n;
            PL:      pass = !n;
            VS:      pass = v;
            VC:      pass = !v;
            HI:      pass = c && !z;
            LS:      pass = !c || z;
            GE:      pass = (n == v);
            LT:      pass = (n != v);
            GT:      pass = !z && (n == v);
            LE:      pass = z || (n != v);
            AL:      pass = 1'b1;
            NV:      pass = 1'b0;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_result_stage.sv
// Execute-output stage behind the ALU. Holds the architectural NZCV register,
// annuls ops whose condition fails, counts annulled ops, and hands results to
// writeback through a 2-entry skid buffer.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is a register (high whenever the skid slot is free);
// out_* come only from the main register and stay stable while
// out_valid is high and out_ready is low.
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int N     = 32,
    parameter int RD_W  = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_result,
    input  logic             in_n,
    input  logic             in_z,
    input  logic             in_c,
    input  logic             in_v,
    input  logic [RD_W-1:0]  in_rd,
    input  logic             in_we,
    input  logic             in_set_flags,
    input  logic [3:0]       in_cond,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_result,
    output logic [RD_W-1:0]  out_rd,
    output logic             out_we,
    output logic [3:0]       flags_q,
    output logic [CNT_W-1:0] annul_cnt,
    output logic [1:0]       state_dbg
);

    skid_state_e       state;
    skid_state_e       next_state;
    logic              accept;
    logic              cond_pass;
    logic              entry_we;

    logic [N-1:0]      skid_result;
    logic [RD_W-1:0]   skid_rd;
    logic              skid_we;

    assign accept    = in_valid && in_ready;
    assign entry_we  = in_we && cond_pass;
    assign out_valid = (state != EMPTY);
    assign state_dbg = state;

    // Condition is judged against the architectural flags, not the op's own
    cond_eval u_cond_eval (
        .cond (cond_e'(in_cond)),
        .nzcv (flags_q),
        .pass (cond_pass)
    );

    // Skid buffer occupancy transitions
    always_comb begin
        next_state = state;
        case (state)
            EMPTY: begin
                if (accept) next_state = HALF;
            end
            HALF: begin
                if (accept && !out_ready)      next_state = FULL;
                else if (!accept && out_ready) next_state = EMPTY;
            end
            FULL: begin
                if (out_ready) next_state = HALF;
            end
            default: next_state = EMPTY;
        endcase
    end

    // State register and registered ready (ready whenever the skid slot is free)
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= EMPTY;
            in_ready <= 1'b0;
        end else begin
            state    <= next_state;
            in_ready <= (next_state != FULL);
        end
    end

    // Main and skid entry registers; new ops go to main unless it is stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            out_result  <= '0;
            out_rd      <= '0;
            out_we      <= 1'b0;
            skid_result <= '0;
            skid_rd     <= '0;
            skid_we     <= 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        out_result <= in_result;
                        out_rd     <= in_rd;
                        out_we     <= entry_we;
                    end
                end
                HALF: begin
                    if (accept && out_ready) begin
                        out_result <= in_result;
                        out_rd     <= in_rd;
                        out_we     <= entry_we;
                    end else if (accept) begin
                        skid_result <= in_result;
                        skid_rd     <= in_rd;
                        skid_we     <= entry_we;
                    end
                end
                FULL: begin
                    if (out_ready) begin
                        out_result <= skid_result;
                        out_rd     <= skid_rd;
                        out_we     <= skid_we;
                    end
                end
                default: begin
                    out_we <= 1'b0;
                end
            endcase
        end
    end

    // Flag update on passing flag-setting ops; saturating count of annulled ops
    always_ff @(posedge clk) begin
        if (rst) begin
            flags_q   <= 4'b0000;
            annul_cnt <= '0;
        end else if (accept) begin
            if (cond_pass) begin
                if (in_set_flags) flags_q <= {in_n, in_z, in_c, in_v};
            end else if (annul_cnt != {CNT_W{1'b1}}) begin
                annul_cnt <= annul_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage: drivers push hand-computed expected
// writeback entries into a queue; a negedge monitor pops and compares each
// entry the DUT hands over.
module tb_alu_result_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_result;
    logic        in_n, in_z, in_c, in_v;
    logic [3:0]  in_rd;
    logic        in_we;
    logic        in_set_flags;
    logic [3:0]  in_cond;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [3:0]  out_rd;
    logic        out_we;
    logic [3:0]  flags_q;
    logic [15:0] annul_cnt;
    logic [1:0]  state_dbg;

    int n_tests = 0;
    int n_fail  = 0;

    // {result, rd, we}
    logic [36:0] exp_q[$];

    alu_result_stage #(.N(32), .RD_W(4), .CNT_W(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_result    (in_result),
        .in_n         (in_n),
        .in_z         (in_z),
        .in_c         (in_c),
        .in_v         (in_v),
        .in_rd        (in_rd),
        .in_we        (in_we),
        .in_set_flags (in_set_flags),
        .in_cond      (in_cond),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_rd       (out_rd),
        .out_we       (out_we),
        .flags_q      (flags_q),
        .annul_cnt    (annul_cnt),
        .state_dbg    (state_dbg)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one op starting at a negedge; returns at the negedge after acceptance
    task automatic send(input logic [31:0] r, input logic [3:0] rd, input logic we,
                        input logic sf, input logic [3:0] cond, input logic [3:0] nzcv,
                        input logic exp_we);
        int waited;
        waited       = 0;
        in_valid     = 1'b1;
        in_result    = r;
        in_rd        = rd;
        in_we        = we;
        in_set_flags = sf;
        in_cond      = cond;
        {in_n, in_z, in_c, in_v} = nzcv;
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: in_ready stuck low for op %0h", r);
            in_valid = 1'b0;
        end else begin
            exp_q.push_back({r, rd, exp_we});
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    // Change out_ready just after a rising edge, then realign to a negedge
    task automatic set_out_ready(input logic v);
        @(posedge clk);
        #1 out_ready = v;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_unexpected: got %0h/%0h/%0b with nothing expected",
                         out_result, out_rd, out_we);
            end else begin
                logic [36:0] e;
                e = exp_q.pop_front();
                check("sb_entry", {27'd0, out_result, out_rd, out_we}, {27'd0, e});
            end
        end
    end

    initial begin
        rst = 1'b1;
        in_valid = 1'b1;
        in_result = 32'hDEAD_BEEF;
        {in_n, in_z, in_c, in_v} = 4'b1111;
        in_rd = 4'd7;
        in_we = 1'b1;
        in_set_flags = 1'b1;
        in_cond = 4'hE;
        out_ready = 1'b1;

        // 1: reset held with in_valid high
        repeat (2) begin
            @(negedge clk);
            check("rst_in_ready", {63'd0, in_ready}, 64'd0);
            check("rst_out_valid", {63'd0, out_valid}, 64'd0);
            check("rst_flags", {60'd0, flags_q}, 64'd0);
        end
        check("rst_annul", {48'd0, annul_cnt}, 64'd0);
        check("rst_out_result", {32'd0, out_result}, 64'd0);
        rst = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("post_rst_out_valid", {63'd0, out_valid}, 64'd0);

        // 2: first op, AL, sets Z
        send(32'h0, 4'd3, 1'b1, 1'b1, 4'hE, 4'b0100, 1'b1);
        check("t2_out_valid", {63'd0, out_valid}, 64'd1);
        check("t2_out_result", {32'd0, out_result}, 64'd0);
        check("t2_out_rd", {60'd0, out_rd}, 64'd3);
        check("t2_out_we", {63'd0, out_we}, 64'd1);
        check("t2_flags", {60'd0, flags_q}, 64'h4);

        // 3: back-to-back flag use, EQ passes then NE fails
        send(32'h5, 4'd1, 1'b1, 1'b1, 4'hE, 4'b0100, 1'b1);
        send(32'h6, 4'd2, 1'b1, 1'b0, 4'h0, 4'b0000, 1'b1);
        send(32'h7, 4'd4, 1'b1, 1'b0, 4'h1, 4'b0000, 1'b0);
        check("t3_annul", {48'd0, annul_cnt}, 64'd1);
        check("t3_flags", {60'd0, flags_q}, 64'h4);

        // 5: failed op must not touch flags even with set_flags
        send(32'h8, 4'd5, 1'b1, 1'b1, 4'hE, 4'b0000, 1'b1);
        check("t5_flags_clear", {60'd0, flags_q}, 64'h0);
        send(32'h9, 4'd6, 1'b1, 1'b1, 4'h0, 4'b1111, 1'b0);
        check("t5_flags_kept", {60'd0, flags_q}, 64'h0);
        check("t5_annul", {48'd0, annul_cnt}, 64'd2);

        // Condition sweep with flags N=1 Z=0 C=1 V=0
        send(32'h100, 4'd0, 1'b1, 1'b1, 4'hE, 4'b1010, 1'b1);
        send(32'h10A, 4'd1, 1'b1, 1'b0, 4'hA, 4'b0000, 1'b0); // GE
        send(32'h10B, 4'd2, 1'b1, 1'b0, 4'hB, 4'b0000, 1'b1); // LT
        send(32'h108, 4'd3, 1'b1, 1'b0, 4'h8, 4'b0000, 1'b1); // HI
        send(32'h109, 4'd4, 1'b1, 1'b0, 4'h9, 4'b0000, 1'b0); // LS
        send(32'h104, 4'd5, 1'b1, 1'b0, 4'h4, 4'b0000, 1'b1); // MI
        send(32'h105, 4'd6, 1'b1, 1'b0, 4'h5, 4'b0000, 1'b0); // PL
        send(32'h106, 4'd7, 1'b1, 1'b0, 4'h6, 4'b0000, 1'b0); // VS
        send(32'h107, 4'd8, 1'b1, 1'b0, 4'h7, 4'b0000, 1'b1); // VC
        send(32'h102, 4'd9, 1'b1, 1'b0, 4'h2, 4'b0000, 1'b1); // CS
        send(32'h103, 4'd10, 1'b1, 1'b0, 4'h3, 4'b0000, 1'b0); // CC
        send(32'h10C, 4'd11, 1'b1, 1'b0, 4'hC, 4'b0000, 1'b0); // GT
        send(32'h10D, 4'd12, 1'b1, 1'b0, 4'hD, 4'b0000, 1'b1); // LE
        send(32'h10F, 4'd13, 1'b1, 1'b0, 4'hF, 4'b0000, 1'b0); // NV
        send(32'h110, 4'd14, 1'b1, 1'b0, 4'h0, 4'b0000, 1'b0); // EQ
        send(32'h111, 4'd15, 1'b1, 1'b0, 4'h1, 4'b0000, 1'b1); // NE
        send(32'h112, 4'd1, 1'b0, 1'b0, 4'hE, 4'b0000, 1'b0); // AL, no write
        check("sweep_annul", {48'd0, annul_cnt}, 64'd10);
        check("sweep_flags", {60'd0, flags_q}, 64'hA);
        idle(3);

        // 4: stall fills main and skid, third op waits
        set_out_ready(1'b0);
        send(32'h11, 4'd1, 1'b1, 1'b0, 4'hE, 4'b0000, 1'b1);
        send(32'h22, 4'd2, 1'b1, 1'b0, 4'hE, 4'b0000, 1'b1);
        check("t4_full_in_ready", {63'd0, in_ready}, 64'd0);
        fork
            send(32'h33, 4'd3, 1'b1, 1'b0, 4'hE, 4'b0000, 1'b1);
            begin
                repeat (3) begin
                    @(negedge clk);
                    check("t4_stall_in_ready", {63'd0, in_ready}, 64'd0);
                    check("t4_stall_result", {32'd0, out_result}, 64'h11);
                    check("t4_stall_valid", {63'd0, out_valid}, 64'd1);
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        idle(4);
        check("t4_drained", {63'd0, out_valid}, 64'd0);

        // 6a: reset while FULL discards both entries
        set_out_ready(1'b0);
        send(32'hAA, 4'd1, 1'b1, 1'b0, 4'hE, 4'b0000, 1'b1);
        send(32'hBB, 4'd2, 1'b1, 1'b0, 4'hE, 4'b0000, 1'b1);
        check("t6_full_state", {62'd0, state_dbg}, 64'd2);
        rst = 1'b1;
        @(negedge clk);
        check("t6_rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("t6_rst_in_ready", {63'd0, in_ready}, 64'd0);
        check("t6_rst_annul", {48'd0, annul_cnt}, 64'd0);
        exp_q.delete();
        rst = 1'b0;
        @(negedge clk);
        check("t6_post_in_ready", {63'd0, in_ready}, 64'd1);
        check("t6_post_out_valid", {63'd0, out_valid}, 64'd0);
        set_out_ready(1'b1);

        // 6b: saturate the annul counter with NV ops
        for (int i = 0; i < 65534; i++)
            send(i, i[3:0], 1'b1, 1'b1, 4'hF, 4'b1111, 1'b0);
        check("sat_fffe", {48'd0, annul_cnt}, 64'hFFFE);
        send(32'h1, 4'd1, 1'b1, 1'b0, 4'hF, 4'b0000, 1'b0);
        check("sat_ffff", {48'd0, annul_cnt}, 64'hFFFF);
        send(32'h2, 4'd2, 1'b1, 1'b0, 4'hF, 4'b0000, 1'b0);
        send(32'h3, 4'd3, 1'b1, 1'b0, 4'h0, 4'b0000, 1'b0);
        check("sat_hold", {48'd0, annul_cnt}, 64'hFFFF);
        check("sat_flags", {60'd0, flags_q}, 64'h0);

        // idle with garbage on inputs must produce nothing
        in_result = 32'hFFFF_FFFF;
        in_cond = 4'hE;
        idle(5);
        check("final_queue_empty", {32'd0, 32'(exp_q.size())}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
